// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port arbiter: access width codes,
// arbiter state encoding and the owner selector used by the request mux.
package dmem_pkg;

    // Access width codes shared by both request ports and the memory
    localparam logic [2:0] WIDTH_B  = 3'b000;
    localparam logic [2:0] WIDTH_H  = 3'b001;
    localparam logic [2:0] WIDTH_W  = 3'b010;
    localparam logic [2:0] WIDTH_BU = 3'b011;
    localparam logic [2:0] WIDTH_HU = 3'b100;

    // Arbiter state: who owned the memory in the previous cycle
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_C_OWN   = 2'd1,
        ST_E_OWN   = 2'd2,
        ST_E_BURST = 2'd3
    } arb_state_t;

    // Owner of the memory in the current cycle
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_C    = 2'd1,
        OWN_E    = 2'd2
    } owner_t;

endpackage

// File: rtl/dmem_req_mux.sv
// Steers the current owner's access fields onto the memory interface.
// With no owner every memory-side signal is held at zero.
module dmem_req_mux
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  owner_t            owner_i,
    input  logic              c_we_i,
    input  logic [2:0]        c_width_i,
    input  logic [ADDR_W-1:0] c_addr_i,
    input  logic [31:0]       c_wdata_i,
    input  logic              e_we_i,
    input  logic [2:0]        e_width_i,
    input  logic [ADDR_W-1:0] e_addr_i,
    input  logic [31:0]       e_wdata_i,
    output logic              mem_we_o,
    output logic              mem_re_o,
    output logic [2:0]        mem_width_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o
);

    // Select the winner's fields; a granted non-store is a read
    always_comb begin
        mem_we_o    = 1'b0;
        mem_re_o    = 1'b0;
        mem_width_o = 3'b000;
        mem_addr_o  = '0;
        mem_wdata_o = 32'h0;
        unique case (owner_i)
            OWN_C: begin
                mem_we_o    = c_we_i;
                mem_re_o    = ~c_we_i;
                mem_width_o = c_width_i;
                mem_addr_o  = c_addr_i;
                mem_wdata_o = c_wdata_i;
            end
            OWN_E: begin
                mem_we_o    = e_we_i;
                mem_re_o    = ~e_we_i;
                mem_width_o = e_width_i;
                mem_addr_o  = e_addr_i;
                mem_wdata_o = e_wdata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one single-port data memory between the CPU MEM stage (port C) and
// an external loader/DMA master (port E). C has fixed priority, E is protected
// by an anti-starvation wait counter and may lock the memory for bounded bursts.
// Load data is registered and returned to the winner one cycle after the grant.
module dmem_port_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MAX_WAIT  = 4,
    parameter int MAX_BURST = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              c_req_i,
    input  logic              c_we_i,
    input  logic [2:0]        c_width_i,
    input  logic [ADDR_W-1:0] c_addr_i,
    input  logic [31:0]       c_wdata_i,
    output logic              c_gnt_o,
    output logic              c_stall_o,
    output logic              c_rvalid_o,
    output logic [31:0]       c_rdata_o,
    input  logic              e_req_i,
    input  logic              e_we_i,
    input  logic [2:0]        e_width_i,
    input  logic [ADDR_W-1:0] e_addr_i,
    input  logic [31:0]       e_wdata_i,
    input  logic              e_lock_i,
    output logic              e_gnt_o,
    output logic              e_rvalid_o,
    output logic [31:0]       e_rdata_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    output logic [2:0]        mem_width_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam logic [3:0] MAX_WAIT_C  = 4'(MAX_WAIT);
    localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

    arb_state_t  state_q, state_d;
    owner_t      owner;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [3:0]  burst_cnt_q, burst_cnt_d;
    logic        c_rvalid_q, c_rvalid_d;
    logic        e_rvalid_q, e_rvalid_d;
    logic [31:0] c_rdata_q, c_rdata_d;
    logic [31:0] e_rdata_q, e_rdata_d;

    // State, counters and response registers; reset drops any pending response
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= 4'd0;
            burst_cnt_q <= 4'd0;
            c_rvalid_q  <= 1'b0;
            e_rvalid_q  <= 1'b0;
            c_rdata_q   <= 32'h0;
            e_rdata_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            c_rvalid_q  <= c_rvalid_d;
            e_rvalid_q  <= e_rvalid_d;
            c_rdata_q   <= c_rdata_d;
            e_rdata_q   <= e_rdata_d;
        end
    end

    // Arbitration in priority order, then next state from the chosen owner
    always_comb begin
        owner = OWN_NONE;
        if (state_q == ST_E_BURST && e_req_i && e_lock_i && burst_cnt_q < MAX_BURST_C) begin
            owner = OWN_E;
        end else if (e_req_i && wait_cnt_q == MAX_WAIT_C) begin
            owner = OWN_E;
        end else if (c_req_i) begin
            owner = OWN_C;
        end else if (e_req_i) begin
            owner = OWN_E;
        end

        unique case (owner)
            OWN_C:   state_d = ST_C_OWN;
            OWN_E:   state_d = e_lock_i ? ST_E_BURST : ST_E_OWN;
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant and stall outputs depend only on requests and state, never on read data
    always_comb begin
        c_gnt_o   = (owner == OWN_C);
        e_gnt_o   = (owner == OWN_E);
        c_stall_o = c_req_i & ~c_gnt_o;
    end

    // Wait counter tracks E losing to C; burst counter tracks a locked E run
    always_comb begin
        wait_cnt_d = 4'd0;
        if (e_req_i && owner == OWN_C) begin
            wait_cnt_d = (wait_cnt_q < MAX_WAIT_C) ? wait_cnt_q + 4'd1 : wait_cnt_q;
        end

        burst_cnt_d = 4'd0;
        if (owner == OWN_E && e_lock_i) begin
            if (state_q == ST_E_BURST) begin
                burst_cnt_d = (burst_cnt_q == 4'hF) ? burst_cnt_q : burst_cnt_q + 4'd1;
            end else begin
                burst_cnt_d = 4'd1;
            end
        end
    end

    // Capture load data for whichever port wins a read; the other port holds
    always_comb begin
        c_rvalid_d = (owner == OWN_C) && !c_we_i;
        e_rvalid_d = (owner == OWN_E) && !e_we_i;
        c_rdata_d  = c_rvalid_d ? mem_rdata_i : c_rdata_q;
        e_rdata_d  = e_rvalid_d ? mem_rdata_i : e_rdata_q;
    end

    assign c_rvalid_o = c_rvalid_q;
    assign e_rvalid_o = e_rvalid_q;
    assign c_rdata_o  = c_rdata_q;
    assign e_rdata_o  = e_rdata_q;

    dmem_req_mux #(
        .ADDR_W (ADDR_W)
    ) u_req_mux (
        .owner_i     (owner),
        .c_we_i      (c_we_i),
        .c_width_i   (c_width_i),
        .c_addr_i    (c_addr_i),
        .c_wdata_i   (c_wdata_i),
        .e_we_i      (e_we_i),
        .e_width_i   (e_width_i),
        .e_addr_i    (e_addr_i),
        .e_wdata_i   (e_wdata_i),
        .mem_we_o    (mem_we_o),
        .mem_re_o    (mem_re_o),
        .mem_width_o (mem_width_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o)
    );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: a byte-array memory answers the arbiter, and a
// rule-level reference model predicts grants, memory drive and load responses.
module tb_dmem_port_arbiter;
    import dmem_pkg::*;

    localparam int MAX_WAIT  = 4;
    localparam int MAX_BURST = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        c_req_i, c_we_i, e_req_i, e_we_i, e_lock_i;
    logic [2:0]  c_width_i, e_width_i;
    logic [31:0] c_addr_i, c_wdata_i, e_addr_i, e_wdata_i;
    logic        c_gnt_o, c_stall_o, c_rvalid_o, e_gnt_o, e_rvalid_o;
    logic [31:0] c_rdata_o, e_rdata_o;
    logic        mem_we_o, mem_re_o;
    logic [2:0]  mem_width_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    dmem_port_arbiter #(
        .ADDR_W(32), .MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .c_req_i(c_req_i), .c_we_i(c_we_i), .c_width_i(c_width_i),
        .c_addr_i(c_addr_i), .c_wdata_i(c_wdata_i),
        .c_gnt_o(c_gnt_o), .c_stall_o(c_stall_o),
        .c_rvalid_o(c_rvalid_o), .c_rdata_o(c_rdata_o),
        .e_req_i(e_req_i), .e_we_i(e_we_i), .e_width_i(e_width_i),
        .e_addr_i(e_addr_i), .e_wdata_i(e_wdata_i), .e_lock_i(e_lock_i),
        .e_gnt_o(e_gnt_o), .e_rvalid_o(e_rvalid_o), .e_rdata_o(e_rdata_o),
        .mem_we_o(mem_we_o), .mem_re_o(mem_re_o), .mem_width_o(mem_width_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- memory environment (256 bytes, little endian) -------
    logic [7:0] mem_bytes [0:255];
    logic       mem_clr;
    logic [7:0] ea, rb0, rb1, rb2, rb3;

    always @(posedge clk_i) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem_bytes[i] <= 8'h00;
        end else if (mem_we_o) begin
            mem_bytes[mem_addr_o[7:0]] <= mem_wdata_o[7:0];
            if (mem_width_o != WIDTH_B && mem_width_o != WIDTH_BU)
                mem_bytes[mem_addr_o[7:0] + 8'd1] <= mem_wdata_o[15:8];
            if (mem_width_o == WIDTH_W) begin
                mem_bytes[mem_addr_o[7:0] + 8'd2] <= mem_wdata_o[23:16];
                mem_bytes[mem_addr_o[7:0] + 8'd3] <= mem_wdata_o[31:24];
            end
        end
    end

    always_comb begin
        ea  = mem_addr_o[7:0];
        rb0 = mem_bytes[ea];
        rb1 = mem_bytes[ea + 8'd1];
        rb2 = mem_bytes[ea + 8'd2];
        rb3 = mem_bytes[ea + 8'd3];
        case (mem_width_o)
            WIDTH_B:  mem_rdata_i = {{24{rb0[7]}}, rb0};
            WIDTH_H:  mem_rdata_i = {{16{rb1[7]}}, rb1, rb0};
            WIDTH_BU: mem_rdata_i = {24'h0, rb0};
            WIDTH_HU: mem_rdata_i = {16'h0, rb1, rb0};
            default:  mem_rdata_i = {rb3, rb2, rb1, rb0};
        endcase
    end

    // ---------------- reference model ----------------
    logic [7:0]  ref_mem [0:255];
    bit          m_locked;      // previous cycle's winner was E with lock held
    int          m_wait, m_burst, m_win;
    logic        exp_c_rvalid, exp_e_rvalid;
    logic [31:0] exp_c_rdata, exp_e_rdata;
    logic        obs_cg, obs_eg, obs_cs;
    int          total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [7:0] a, input logic [2:0] w);
        logic [7:0] b0, b1, b2, b3;
        b0 = ref_mem[a]; b1 = ref_mem[a + 8'd1]; b2 = ref_mem[a + 8'd2]; b3 = ref_mem[a + 8'd3];
        case (w)
            WIDTH_B:  return {{24{b0[7]}}, b0};
            WIDTH_H:  return {{16{b1[7]}}, b1, b0};
            WIDTH_BU: return {24'h0, b0};
            WIDTH_HU: return {16'h0, b1, b0};
            default:  return {b3, b2, b1, b0};
        endcase
    endfunction

    function automatic void ref_store(input logic [7:0] a, input logic [2:0] w, input logic [31:0] d);
        int n;
        n = (w == WIDTH_W) ? 4 : ((w == WIDTH_H || w == WIDTH_HU) ? 2 : 1);
        for (int k = 0; k < n; k++) ref_mem[a + 8'(k)] = d[8*k +: 8];
    endfunction

    // 0 = nobody, 1 = C, 2 = E
    function automatic int model_pick();
        if (m_locked && e_req_i && e_lock_i && m_burst < MAX_BURST) return 2;
        if (e_req_i && m_wait == MAX_WAIT) return 2;
        if (c_req_i) return 1;
        if (e_req_i) return 2;
        return 0;
    endfunction

    function automatic void model_reset();
        m_locked = 0; m_wait = 0; m_burst = 0; m_win = 0;
        exp_c_rvalid = 0; exp_e_rvalid = 0; exp_c_rdata = 0; exp_e_rdata = 0;
    endfunction

    task automatic set_c(input logic req, input logic we, input logic [2:0] w,
                         input logic [31:0] a, input logic [31:0] d);
        c_req_i = req; c_we_i = we; c_width_i = w; c_addr_i = a; c_wdata_i = d;
    endtask

    task automatic set_e(input logic req, input logic we, input logic [2:0] w,
                         input logic [31:0] a, input logic [31:0] d, input logic lock);
        e_req_i = req; e_we_i = we; e_width_i = w; e_addr_i = a; e_wdata_i = d; e_lock_i = lock;
    endtask

    // One clock: called just after a falling edge with inputs already driven
    task automatic cycle();
        int          w;
        logic        we;
        logic [2:0]  wd;
        logic [31:0] ad, wdat, ld;
        #1;
        w = model_pick();
        we = 1'b0; wd = 3'b000; ad = 32'h0; wdat = 32'h0;
        if (w == 1) begin we = c_we_i; wd = c_width_i; ad = c_addr_i; wdat = c_wdata_i; end
        if (w == 2) begin we = e_we_i; wd = e_width_i; ad = e_addr_i; wdat = e_wdata_i; end
        obs_cg = c_gnt_o; obs_eg = e_gnt_o; obs_cs = c_stall_o;
        chk("c_gnt", c_gnt_o, w == 1);
        chk("e_gnt", e_gnt_o, w == 2);
        chk("c_stall", c_stall_o, c_req_i && w != 1);
        chk("mem_we", mem_we_o, w != 0 && we);
        chk("mem_re", mem_re_o, w != 0 && !we);
        chk("mem_width", mem_width_o, wd);
        chk("mem_addr", mem_addr_o, ad);
        chk("mem_wdata", mem_wdata_o, wdat);
        ld = ref_load(ad[7:0], wd);
        @(posedge clk_i);
        exp_c_rvalid = 0; exp_e_rvalid = 0;
        if (w != 0 && we) ref_store(ad[7:0], wd, wdat);
        if (w == 1 && !we) begin exp_c_rvalid = 1; exp_c_rdata = ld; end
        if (w == 2 && !we) begin exp_e_rvalid = 1; exp_e_rdata = ld; end
        m_wait   = (e_req_i && w == 1) ? ((m_wait < MAX_WAIT) ? m_wait + 1 : m_wait) : 0;
        m_burst  = (w == 2 && e_lock_i) ? (m_locked ? ((m_burst < 15) ? m_burst + 1 : 15) : 1) : 0;
        m_locked = (w == 2 && e_lock_i);
        m_win    = w;
        #1;
        chk("c_rvalid", c_rvalid_o, exp_c_rvalid);
        chk("e_rvalid", e_rvalid_o, exp_e_rvalid);
        chk("c_rdata", c_rdata_o, exp_c_rdata);
        chk("e_rdata", e_rdata_o, exp_e_rdata);
        @(negedge clk_i);
    endtask

    task automatic new_txn(output logic we, output logic [2:0] w, output logic [31:0] a,
                           output logic [31:0] d);
        we = 1'($urandom_range(0, 1));
        w  = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 4));
        if (w == WIDTH_W)                       a = 32'($urandom_range(0, 63) * 4);
        else if (w == WIDTH_H || w == WIDTH_HU) a = 32'($urandom_range(0, 127) * 2);
        else                                    a = 32'($urandom_range(0, 255));
        d = $urandom;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    bit          c_pend, e_pend;
    logic        cp_we, ep_we;
    logic [2:0]  cp_w, ep_w;
    logic [31:0] cp_a, cp_d, ep_a, ep_d;
    logic [5:0]  pat6_e, pat6_s;
    logic [15:0] pat16;
    int          e_cnt, n_cyc;

    initial begin
        rst_i = 1'b1; mem_clr = 1'b1;
        set_c(0, 0, 3'b000, 0, 0);
        set_e(0, 0, 3'b000, 0, 0, 0);
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        model_reset();
        @(negedge clk_i);
        mem_clr = 1'b0;
        #1;
        chk("rst_c_rvalid", c_rvalid_o, 0);
        chk("rst_e_rvalid", e_rvalid_o, 0);
        chk("rst_c_rdata", c_rdata_o, 0);
        chk("rst_e_rdata", e_rdata_o, 0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // 1) C only: SW then LW
        set_c(1, 1, WIDTH_W, 32'h40, 32'hA1B2C3D4); cycle();
        chk("t1_sw_gnt", obs_cg, 1);
        set_c(1, 0, WIDTH_W, 32'h40, 0); cycle();
        chk("t1_lw_stall", obs_cs, 0);
        chk("t1_c_rvalid", c_rvalid_o, 1);
        chk("t1_c_rdata", c_rdata_o, 32'hA1B2C3D4);

        // 2) both request for 6 cycles: E forced on the 5th
        set_c(1, 0, WIDTH_W, 32'h40, 0);
        set_e(1, 0, WIDTH_W, 32'h44, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cycle(); pat6_e[i] = obs_eg; pat6_s[i] = obs_cs;
        end
        chk("t2_e_pattern", 32'(pat6_e), 32'h10);
        chk("t2_stall_pattern", 32'(pat6_s), 32'h10);
        set_c(0, 0, 0, 0, 0); set_e(0, 0, 0, 0, 0, 0); cycle();

        // 3a) locked E burst of 10 stores, C idle
        e_cnt = 0; n_cyc = 0;
        for (int i = 0; i < 20 && e_cnt < 10; i++) begin
            set_e(1, 1, WIDTH_W, 32'h80 + 32'(4 * e_cnt), 32'h1000 + 32'(e_cnt), 1);
            cycle(); n_cyc++;
            if (m_win == 2) e_cnt++;
        end
        chk("t3a_cycles", n_cyc, 10);
        set_e(0, 0, 0, 0, 0, 0); cycle();

        // 3b) same burst, C requests once from the second cycle
        e_cnt = 0; n_cyc = 0; c_pend = 0; pat16 = 16'h0;
        for (int i = 0; i < 16 && e_cnt < 10; i++) begin
            if (i == 1) c_pend = 1;
            set_c(c_pend, 0, WIDTH_W, 32'h40, 0);
            set_e(1, 1, WIDTH_W, 32'h80 + 32'(4 * e_cnt), 32'h2000 + 32'(e_cnt), 1);
            cycle(); n_cyc++;
            pat16[i] = obs_eg;
            if (m_win == 2) e_cnt++;
            if (m_win == 1) c_pend = 0;
        end
        chk("t3b_e_pattern", 32'(pat16), 32'h06FF);
        chk("t3b_cycles", n_cyc, 11);
        set_c(0, 0, 0, 0, 0); set_e(0, 0, 0, 0, 0, 0); cycle();

        // 4) same-cycle C SB and E LBU to 0x64, old byte 0x80
        set_c(1, 1, WIDTH_B, 32'h64, 32'h80); cycle();
        set_c(1, 1, WIDTH_B, 32'h64, 32'h55);
        set_e(1, 0, WIDTH_BU, 32'h64, 0, 0); cycle();
        chk("t4_c_wins", obs_cg, 1);
        set_c(0, 0, 0, 0, 0); cycle();
        chk("t4_e_next", obs_eg, 1);
        chk("t4_e_rdata", e_rdata_o, 32'h00000055);

        // 5) E LB of 0x80 sign-extends; C response untouched
        set_e(0, 0, 0, 0, 0, 0);
        set_c(1, 1, WIDTH_B, 32'h64, 32'h80); cycle();
        set_c(0, 0, 0, 0, 0);
        set_e(1, 0, WIDTH_B, 32'h64, 0, 0); cycle();
        chk("t5_e_rvalid", e_rvalid_o, 1);
        chk("t5_e_rdata", e_rdata_o, 32'hFFFFFF80);
        chk("t5_c_rvalid", c_rvalid_o, 0);
        chk("t5_c_rdata", c_rdata_o, 32'hA1B2C3D4);

        // 6) asynchronous reset in the middle of a locked load burst
        set_e(1, 0, WIDTH_W, 32'h80, 0, 1); cycle(); cycle();
        chk("t6_pre_rvalid", e_rvalid_o, 1);
        #2; rst_i = 1'b1; #1;
        chk("t6_c_rvalid", c_rvalid_o, 0);
        chk("t6_e_rvalid", e_rvalid_o, 0);
        chk("t6_c_rdata", c_rdata_o, 0);
        chk("t6_e_rdata", e_rdata_o, 0);
        model_reset();
        set_c(1, 0, WIDTH_W, 32'h40, 0); #1;
        chk("t6_comb_gnt", c_gnt_o, 1);
        @(negedge clk_i); rst_i = 1'b0;
        cycle();
        chk("t6_first_c", obs_cg, 1);
        set_c(0, 0, 0, 0, 0); set_e(0, 0, 0, 0, 0, 0); cycle();

        // random traffic: requesters hold until granted, occasionally withdraw
        c_pend = 0; e_pend = 0;
        for (int n = 0; n < 400; n++) begin
            if (!c_pend) begin
                if ($urandom_range(0, 2) != 0) begin new_txn(cp_we, cp_w, cp_a, cp_d); c_pend = 1; end
            end else if ($urandom_range(0, 19) == 0) c_pend = 0;
            if (!e_pend) begin
                if ($urandom_range(0, 2) != 0) begin new_txn(ep_we, ep_w, ep_a, ep_d); e_pend = 1; end
            end else if ($urandom_range(0, 19) == 0) e_pend = 0;
            set_c(c_pend, cp_we, cp_w, cp_a, cp_d);
            set_e(e_pend, ep_we, ep_w, ep_a, ep_d, 1'($urandom_range(0, 3) != 0));
            cycle();
            if (m_win == 1) c_pend = 0;
            if (m_win == 2) e_pend = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
